// File: rtl/x1_ioctl_loader.sv
// Download loader: filters the ioctl byte stream by index, queues {addr, data} in a small FIFO
// and replays it over a req/ack write port. Optional checksum via X1_LOADER_CHECKSUM_EN.
module x1_ioctl_loader #(
   parameter int unsigned ADDR_W     = 17,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  LOAD_INDEX = 8'h00
) (
   input  logic              clk_sys_i,
   input  logic              reset_i,
   input  logic              ioctl_download_i,
   input  logic [7:0]        ioctl_index_i,
   input  logic              ioctl_wr_i,
   input  logic [24:0]       ioctl_addr_i,
   input  logic [7:0]        ioctl_dout_i,
   output logic              ioctl_wait_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_din_o,
   input  logic              mem_ack_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [15:0]       checksum_o
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DepthC    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] WaitLevel = CW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic              download_q;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d, avail;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_din_q, mem_din_d;
   logic              wait_q, busy_q, done_q, err_q, err_d;

   logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
   logic [7:0]        data_mem_q [FIFO_DEPTH];

   logic accept, in_range, full, push, pop, drop_err, rise;

   always_comb begin
      accept   = ioctl_download_i & ioctl_wr_i & (ioctl_index_i == LOAD_INDEX);
      in_range = (ioctl_addr_i >> ADDR_W) == 25'd0;
      full     = (count_q == DepthC);
      push     = accept & in_range & ~full;
      drop_err = accept & (~in_range | full);
      pop      = mem_req_q & mem_ack_i;
      rise     = ioctl_download_i & ~download_q;

      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);

      // Entries already in storage this cycle; a push shows up one cycle later.
      avail      = count_q - CW'(pop);
      mem_req_d  = (avail != '0);
      mem_addr_d = mem_req_d ? addr_mem_q[rd_ptr_d] : '0;
      mem_din_d  = mem_req_d ? data_mem_q[rd_ptr_d] : '0;

      // An error raised in the LOAD-entry cycle survives the clear.
      err_d = (rise ? 1'b0 : err_q) | drop_err;

      state_d = state_q;
      unique case (state_q)
         StIdle:  if (rise) state_d = StLoad;
         StLoad:  if (!ioctl_download_i) state_d = StDrain;
         StDrain: begin
            if (rise) state_d = StLoad;
            else if (count_q == '0 && !mem_req_q) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_sys_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         download_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         wait_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         download_q <= ioctl_download_i;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         wait_q     <= (count_d >= WaitLevel);
         busy_q     <= (state_d != StIdle);
         done_q     <= (state_d == StDone);
         err_q      <= err_d;
      end
   end

   // Storage is not reset; validity is tracked by the pointers.
   always_ff @(posedge clk_sys_i) begin
      if (push) begin
         addr_mem_q[wr_ptr_q] <= ioctl_addr_i[ADDR_W-1:0];
         data_mem_q[wr_ptr_q] <= ioctl_dout_i;
      end
   end

`ifdef X1_LOADER_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = rise ? 16'h0000 : checksum_q;
      if (push) checksum_d = checksum_d + {8'h00, ioctl_dout_i};
   end

   always_ff @(posedge clk_sys_i) begin
      if (reset_i) checksum_q <= 16'h0000;
      else         checksum_q <= checksum_d;
   end

   assign checksum_o = checksum_q;
`else
   assign checksum_o = 16'h0000;
`endif

   assign ioctl_wait_o = wait_q;
   assign mem_req_o    = mem_req_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_din_o    = mem_din_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_x1_ioctl_loader.sv
// Scoreboard bench for x1_ioctl_loader: stimulus queues expected writes, a monitor checks them.
module tb_x1_ioctl_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        mem_req;
   logic [16:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_ack;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] checksum;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int ack_mode = 0;
   int ack_cyc  = 0;
   logic [24:0] exp_q [$];

   always #5 clk = ~clk;

   x1_ioctl_loader #(
      .ADDR_W    (17),
      .FIFO_DEPTH(4),
      .LOAD_INDEX(8'h00)
   ) dut (
      .clk_sys_i       (clk),
      .reset_i         (reset),
      .ioctl_download_i(ioctl_download),
      .ioctl_index_i   (ioctl_index),
      .ioctl_wr_i      (ioctl_wr),
      .ioctl_addr_i    (ioctl_addr),
      .ioctl_dout_i    (ioctl_dout),
      .ioctl_wait_o    (ioctl_wait),
      .mem_req_o       (mem_req),
      .mem_addr_o      (mem_addr),
      .mem_din_o       (mem_din),
      .mem_ack_i       (mem_ack),
      .busy_o          (busy),
      .done_o          (done),
      .err_o           (err),
      .checksum_o      (checksum)
   );

   function automatic logic [15:0] exp_ck(input logic [15:0] v);
`ifdef X1_LOADER_CHECKSUM_EN
      return v;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Monitor: every accepted write must match the head of the expected queue.
   initial begin
      logic [24:0] e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
         if (!reset && mem_req === 1'b1 && mem_ack === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write actual=0x%0h required=none", {mem_addr, mem_din});
            end else begin
               e = exp_q.pop_front();
               if ({mem_addr, mem_din} !== e) begin
                  failures++;
                  $display("FAIL write_data actual=0x%0h required=0x%0h", {mem_addr, mem_din}, e);
               end
            end
         end
      end
   end

   // Ack driver: 0 = held low, 1 = tied high, 2 = every third cycle.
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ack_cyc++;
         case (ack_mode)
            1:       mem_ack = 1'b1;
            2:       mem_ack = (ack_cyc % 3 == 0);
            default: mem_ack = 1'b0;
         endcase
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                         input bit store);
      ioctl_wr    = 1'b1;
      ioctl_index = idx;
      ioctl_addr  = a;
      ioctl_dout  = d;
      if (store) exp_q.push_back({a[16:0], d});
      @(posedge clk);
      #1;
      ioctl_wr    = 1'b0;
      ioctl_index = 8'h00;
   endtask

   task automatic start_load();
      ioctl_download = 1'b1;
      tick(1);
   endtask

   task automatic finish_load(input string name);
      int d0;
      int n;
      d0 = done_cnt;
      ioctl_download = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < 100) begin
         tick(1);
         n++;
      end
      check({name, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
      tick(3);
      check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({name, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int d0;
      bit early;
      reset = 1'b1;
      ioctl_download = 1'b0;
      ioctl_index = 8'h00;
      ioctl_wr = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      tick(3);
      reset = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_wait", 32'(ioctl_wait), 32'd0);
      check("rst_checksum", 32'(checksum), 32'd0);

      // Straight load of eight bytes under continuous ack.
      ack_mode = 1;
      start_load();
      check("t1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) strobe(8'h00, 25'(i), 8'(i + 1), 1'b1);
      finish_load("t1");
      check("t1_err", 32'(err), 32'd0);
      check("t1_checksum", 32'(checksum), 32'(exp_ck(16'h0024)));

      // Back-pressure: no ack, strobe every cycle.
      ack_mode = 0;
      tick(1);
      start_load();
      strobe(8'h00, 25'h10, 8'h11, 1'b1);
      strobe(8'h00, 25'h11, 8'h22, 1'b1);
      check("t2_wait_2", 32'(ioctl_wait), 32'd0);
      strobe(8'h00, 25'h12, 8'h33, 1'b1);
      check("t2_wait_3", 32'(ioctl_wait), 32'd1);
      check("t2_err_3", 32'(err), 32'd0);
      strobe(8'h00, 25'h13, 8'h44, 1'b1);
      check("t2_err_4", 32'(err), 32'd0);
      strobe(8'h00, 25'h14, 8'h55, 1'b0);
      check("t2_err_5", 32'(err), 32'd1);
      check("t2_checksum", 32'(checksum), 32'(exp_ck(16'h00AA)));
      ack_mode = 1;
      finish_load("t2");

      // Out-of-range address next to the top valid byte.
      start_load();
      check("t3_err_clear", 32'(err), 32'd0);
      strobe(8'h00, 25'h20000, 8'h99, 1'b0);
      check("t3_err", 32'(err), 32'd1);
      strobe(8'h00, 25'h1FFFF, 8'h5A, 1'b1);
      finish_load("t3");
      check("t3_err_sticky", 32'(err), 32'd1);
      check("t3_checksum", 32'(checksum), 32'(exp_ck(16'h005A)));

      // Foreign index: ignored, no error.
      start_load();
      for (int i = 0; i < 3; i++) strobe(8'h01, 25'(i), 8'hC0 + 8'(i), 1'b0);
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_err", 32'(err), 32'd0);
      finish_load("t4");
      check("t4_checksum", 32'(checksum), 32'd0);

      // Slow drain: three entries queued, ack every third cycle.
      ack_mode = 0;
      start_load();
      for (int i = 0; i < 3; i++) strobe(8'h00, 25'h100 + 25'(i), 8'h70 + 8'(i), 1'b1);
      d0 = done_cnt;
      ioctl_download = 1'b0;
      ack_mode = 2;
      tick(1);
      check("t5_busy_drain", 32'(busy), 32'd1);
      early = 1'b0;
      for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
         if (done_cnt != d0) early = 1'b1;
         tick(1);
      end
      check("t5_no_early_done", 32'(early), 32'd0);
      check("t5_drained", 32'(exp_q.size()), 32'd0);
      for (int n = 0; n < 20 && done_cnt == d0; n++) tick(1);
      check("t5_done", 32'(done_cnt - d0), 32'd1);
      tick(2);

      // Reset with an outstanding request.
      ack_mode = 0;
      start_load();
      strobe(8'h00, 25'h40, 8'hE1, 1'b0);
      strobe(8'h00, 25'h41, 8'hE2, 1'b0);
      tick(1);
      check("t6_req_before", 32'(mem_req), 32'd1);
      reset = 1'b1;
      ioctl_download = 1'b0;
      tick(1);
      check("t6_req", 32'(mem_req), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_wait", 32'(ioctl_wait), 32'd0);
      check("t6_err", 32'(err), 32'd0);
      check("t6_done", 32'(done), 32'd0);
      check("t6_addr", 32'(mem_addr), 32'd0);
      check("t6_din", 32'(mem_din), 32'd0);
      check("t6_checksum", 32'(checksum), 32'd0);
      reset = 1'b0;
      ack_mode = 1;
      tick(1);
      start_load();
      strobe(8'h00, 25'h0, 8'hA1, 1'b1);
      strobe(8'h00, 25'h1, 8'hA2, 1'b1);
      finish_load("t6");
      check("t6_checksum_after", 32'(checksum), 32'(exp_ck(16'h0143)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/x1_ioctl_loader.md
# x1_ioctl_loader

Download-side loader between the HPS/sim `ioctl_*` byte stream and the `sharpx1` core's ROM/RAM write port. It filters bytes by `ioctl_index` and buffers them in a small address/data FIFO. It replays them to memory over a req/ack handshake and throttles the source with `ioctl_wait`. It reports completion, overflow errors and, optionally, a running checksum of the loaded image.

## Interface
Parameters:
- `ADDR_W`, 17: memory address width; image bytes at `ioctl_addr >= 2**ADDR_W` are rejected.
- `FIFO_DEPTH`, 4: entries of {addr, data}; power of two, at least 4.
- `LOAD_INDEX`, 8'h00: `ioctl_index` value this loader accepts.

Ports:
- `clk_sys` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `ioctl_download` in 1: transfer active.
- `ioctl_index` in 8: image selector.
- `ioctl_wr` in 1: byte strobe, one cycle per byte.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: source must hold off new strobes.
- `mem_req` out 1: write request, held until acknowledged.
- `mem_addr` out ADDR_W: write address.
- `mem_din` out 8: write data.
- `mem_ack` in 1: memory accepted the current request.
- `busy` out 1: loader not IDLE.
- `done` out 1: one-cycle pulse when a load has fully drained.
- `err` out 1: sticky; set on FIFO overflow or out-of-range address.
- `checksum` out 16: additive checksum of accepted bytes.

## Operation
- Accept condition: `ioctl_download & ioctl_wr & (ioctl_index == LOAD_INDEX)`.
- Accepted byte with `ioctl_addr[24:ADDR_W] == 0` is pushed as {`ioctl_addr[ADDR_W-1:0]`, `ioctl_dout`}.
- Out-of-range byte: not pushed; `err` set.
- Push when FIFO full: byte dropped; `err` set.
- Strobes with a non-matching index are ignored entirely; no error.
- Pop: `mem_req & mem_ack`. `mem_addr`/`mem_din` show the FIFO head and stay stable while `mem_req` is high.
- Count: push-only +1, pop-only -1, simultaneous push and pop unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- `ioctl_wait` is registered. It is 1 when the next-cycle count is `>= FIFO_DEPTH-1`, leaving one slot for a strobe already in flight.

State machine:
- IDLE → LOAD on `ioctl_download` rising edge (sampled vs. previous-cycle register). On this edge `err` and checksum clear.
- LOAD → DRAIN when `ioctl_download` falls. A strobe in that same cycle is still rejected, because download is low.
- DRAIN → DONE when count == 0 and `mem_req` == 0.
- DONE → IDLE unconditionally; `done` = 1 for exactly this cycle.
- Download rising while in DRAIN: go to LOAD, FIFO contents retained, no `done` pulse.
- `busy` = (state != IDLE).

Reset:
- All outputs 0, FIFO emptied, state IDLE. Applies mid-transfer too: an outstanding `mem_req` is dropped without waiting for ack.

## Timing
- Empty FIFO: `ioctl_wr` at edge N → `mem_req` high after edge N+1, one cycle latency.
- `mem_ack` may arrive in the same cycle `mem_req` rises or any cycle later.
- Each ack pops one entry. The next head is presented in the following cycle with `mem_req` still high if count > 0, giving 1 byte/cycle throughput under continuous ack.
- `ioctl_wait` follows a push that reaches `FIFO_DEPTH-1` entries by one cycle.
- `done` occurs at least 2 cycles after `ioctl_download` falls.

## Configuration
- `X1_LOADER_CHECKSUM_EN` defined:
  - `checksum` = 16-bit wrapping sum of every byte pushed into the FIFO in the current load.
  - Dropped and out-of-range bytes are excluded.
  - Value updates on the edge after the push and is cleared at LOAD entry.
- Not defined: `checksum` is tied to 16'h0000 and no adder is synthesized.

## Test plan
- Reset, then 8 bytes 0x01..0x08 at addr 0..7, index 0, `mem_ack` tied 1 → 8 writes with `mem_addr` 0..7 and matching data, `done` pulses once, `err` = 0, checksum = 0x0024 (macro on) or 0x0000 (off).
- `mem_ack` held 0, strobe every cycle → `ioctl_wait` high after the 3rd push. A 4th byte already in flight is stored. A 5th forced strobe is dropped and `err` = 1.
- Byte at `ioctl_addr` = 0x20000 with `ADDR_W` = 17 → no `mem_req`, `err` = 1, load still ends with `done`.
- Bytes with index 0x01 → no writes, `err` = 0, `busy` high during download, `done` pulses at its end.
- Download falls with 3 entries queued and ack every 3rd cycle → state stays DRAIN, `done` fires only after the last ack.
- `reset` asserted while `mem_req` = 1 with 2 entries queued → next cycle all outputs 0. A fresh load then writes from addr 0 correctly.
